// File: rtl/pwl_act_pkg.sv
// pwl_act_pkg: shared types and segment constants for the piecewise-linear
// activation pipeline.
//   mode_t   : per-beat activation select (tanh, sigmoid, relu, identity)
//   seg_t    : magnitude segment chosen in S1, consumed in S2
//   seg_base / seg_shift / seg_bias : segment line parameters for a given
//              fraction width; r = bias + ((m - base) >> shift)
//   sat_val  : saturated magnitude, one LSB below 1.0
//   sat_limit: magnitude at and above which the result saturates (3.0)
package pwl_act_pkg;

    typedef enum logic [1:0] {
        MODE_TANH    = 2'd0,
        MODE_SIGMOID = 2'd1,
        MODE_RELU    = 2'd2,
        MODE_IDENT   = 2'd3
    } mode_t;

    localparam int MODE_W = 2;
    localparam int SEG_W  = 3;

    typedef enum logic [SEG_W-1:0] {
        SEG0    = 3'd0,
        SEG1    = 3'd1,
        SEG2    = 3'd2,
        SEG3    = 3'd3,
        SEG_SAT = 3'd4
    } seg_t;

    // Lower magnitude bound of each segment; the bound of the next segment
    // doubles as the upper limit of the current one.
    function automatic int seg_base(input seg_t seg, input int frac_w);
        case (seg)
            SEG1:    return 1 << (frac_w - 1);   // 0.5
            SEG2:    return 1 << frac_w;         // 1.0
            SEG3:    return 7 << (frac_w - 2);   // 1.75
            default: return 0;
        endcase
    endfunction

    function automatic int seg_shift(input seg_t seg);
        case (seg)
            SEG1:    return 1;
            SEG2:    return 2;
            SEG3:    return 5;
            default: return 0;
        endcase
    endfunction

    function automatic int seg_bias(input seg_t seg, input int frac_w);
        case (seg)
            SEG1:    return 1 << (frac_w - 1);   // 0.5
            SEG2:    return 3 << (frac_w - 2);   // 0.75
            SEG3:    return 15 << (frac_w - 4);  // 0.9375
            default: return 0;
        endcase
    endfunction

    function automatic int sat_val(input int frac_w);
        return (1 << frac_w) - 1;
    endfunction

    function automatic int sat_limit(input int frac_w);
        return 3 << frac_w;                      // 3.0
    endfunction

endpackage

// File: rtl/pwl_stage_reg.sv
// pwl_stage_reg: one valid/ready register slice of the activation pipeline.
//   clk, rst_n            : clock, asynchronous active-low reset
//   up_valid/up_ready     : upstream handshake, up_data is the payload
//   down_valid/down_ready : downstream handshake, down_data is the payload
// Handshake: a beat transfers on a port when valid && ready are both high at
// the rising clock edge; valid never depends on ready, and a presented beat
// stays unchanged until it transfers. The slice loads whenever it is empty or
// its own beat is leaving, so bubbles collapse and ready ripples back
// combinationally.
module pwl_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_data,
    output logic         down_valid,
    input  logic         down_ready,
    output logic [W-1:0] down_data
);

    assign up_ready = !down_valid || down_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            down_valid <= 1'b0;
            down_data  <= '0;
        end else if (up_ready) begin
            down_valid <= up_valid;
            if (up_valid) begin
                down_data <= up_data;
            end
        end
    end

endmodule

// File: rtl/pwl_act_pipe.sv
// pwl_act_pipe: three-stage streaming piecewise-linear activation unit.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake; in_mode and in_data travel with it
//   in_mode             : 0 tanh, 1 sigmoid, 2 relu, 3 identity
//   in_data             : LANES signed Q(DATA_W-FRAC_W).FRAC_W words
//   out_valid/out_ready : output handshake
//   out_data            : LANES signed results, same lane packing
// S1 folds the input to sign + magnitude and picks a segment, S2 evaluates
// the segment line, S3 applies the mode-specific output select. The mode
// rides in the top bits of each slice payload.
module pwl_act_pipe
    import pwl_act_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int LANES  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_mode,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data
);

    // S1 lane payload: {seg, neg, m, x}; S2 lane payload: {t, x}
    localparam int S1_LW = 2 * DATA_W + 1 + SEG_W;
    localparam int S2_LW = 2 * DATA_W;
    localparam int S1_W  = MODE_W + LANES * S1_LW;
    localparam int S2_W  = MODE_W + LANES * S2_LW;
    localparam int S3_W  = LANES * DATA_W;

    localparam logic [DATA_W-1:0] ONE      = DATA_W'(1 << FRAC_W);
    localparam logic [DATA_W-1:0] LIM0     = DATA_W'(seg_base(SEG1, FRAC_W));
    localparam logic [DATA_W-1:0] LIM1     = DATA_W'(seg_base(SEG2, FRAC_W));
    localparam logic [DATA_W-1:0] LIM2     = DATA_W'(seg_base(SEG3, FRAC_W));
    localparam logic [DATA_W-1:0] LIM3     = DATA_W'(sat_limit(FRAC_W));
    localparam logic [DATA_W-1:0] SAT_R    = DATA_W'(sat_val(FRAC_W));
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MAX_POS  = ~MOST_NEG;

    mode_t             in_mode_e;
    mode_t             s2_mode;
    logic [S1_W-1:0]   s1_d_in, s1_d;
    logic [S2_W-1:0]   s2_d_in, s2_d;
    logic [S3_W-1:0]   s3_d_in;
    logic              s1_valid, s2_valid;
    logic              s2_ready, s3_ready;

    assign in_mode_e = mode_t'(in_mode);
    assign s2_mode   = mode_t'(s2_d[S2_W-1 -: MODE_W]);

    assign s1_d_in[S1_W-1 -: MODE_W] = in_mode;
    assign s2_d_in[S2_W-1 -: MODE_W] = s1_d[S1_W-1 -: MODE_W];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        // ---- S1: fold to sign/magnitude, pick segment ----
        logic signed [DATA_W-1:0] x, xs;
        logic        [DATA_W-1:0] m;
        logic                     neg;
        seg_t                     seg;

        always_comb begin
            x   = in_data[l*DATA_W +: DATA_W];
            xs  = (in_mode_e == MODE_SIGMOID) ? (x >>> 1) : x;
            neg = xs[DATA_W-1];
            // -MOST_NEG is not representable; clamp to the largest magnitude
            if (xs == MOST_NEG) begin
                m = MAX_POS;
            end else if (neg) begin
                m = -xs;
            end else begin
                m = xs;
            end
            if (m < LIM0) begin
                seg = SEG0;
            end else if (m < LIM1) begin
                seg = SEG1;
            end else if (m < LIM2) begin
                seg = SEG2;
            end else if (m < LIM3) begin
                seg = SEG3;
            end else begin
                seg = SEG_SAT;
            end
        end

        assign s1_d_in[l*S1_LW +: S1_LW] = {seg, neg, m, x};

        // ---- S2: segment line on the magnitude, then reapply the sign ----
        logic [SEG_W-1:0]  s1_seg_raw;
        seg_t              s1_seg;
        logic              s1_neg;
        logic [DATA_W-1:0] s1_m, s1_x, r, t;

        assign {s1_seg_raw, s1_neg, s1_m, s1_x} = s1_d[l*S1_LW +: S1_LW];
        assign s1_seg = seg_t'(s1_seg_raw);

        always_comb begin
            if (s1_seg == SEG_SAT) begin
                r = SAT_R;
            end else begin
                r = DATA_W'(seg_bias(s1_seg, FRAC_W))
                  + ((s1_m - DATA_W'(seg_base(s1_seg, FRAC_W))) >> seg_shift(s1_seg));
            end
            // Negating the magnitude result keeps tanh exactly odd-symmetric
            t = s1_neg ? -r : r;
        end

        assign s2_d_in[l*S2_LW +: S2_LW] = {t, s1_x};

        // ---- S3: mode-specific output select ----
        logic [DATA_W-1:0] s2_t, s2_x, sum, y;

        assign {s2_t, s2_x} = s2_d[l*S2_LW +: S2_LW];

        always_comb begin
            // t lies in (-1, 1), so t + 1.0 is non-negative and fits
            sum = s2_t + ONE;
            case (s2_mode)
                MODE_TANH:    y = s2_t;
                MODE_SIGMOID: y = sum >> 1;
                MODE_RELU:    y = s2_x[DATA_W-1] ? '0 : s2_x;
                default:      y = s2_x;
            endcase
        end

        assign s3_d_in[l*DATA_W +: DATA_W] = y;
    end

    pwl_stage_reg #(.W(S1_W)) u_s1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid   (in_valid),
        .up_ready   (in_ready),
        .up_data    (s1_d_in),
        .down_valid (s1_valid),
        .down_ready (s2_ready),
        .down_data  (s1_d)
    );

    pwl_stage_reg #(.W(S2_W)) u_s2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid   (s1_valid),
        .up_ready   (s2_ready),
        .up_data    (s2_d_in),
        .down_valid (s2_valid),
        .down_ready (s3_ready),
        .down_data  (s2_d)
    );

    pwl_stage_reg #(.W(S3_W)) u_s3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid   (s2_valid),
        .up_ready   (s3_ready),
        .up_data    (s3_d_in),
        .down_valid (out_valid),
        .down_ready (out_ready),
        .down_data  (out_data)
    );

endmodule

// File: tb/tb_pwl_act_pipe.sv
// tb_pwl_act_pipe: directed bench for pwl_act_pipe, one single-lane instance
// (Q8.8) and one four-lane instance sharing clock and reset.
module tb_pwl_act_pipe;
    import pwl_act_pkg::*;

    localparam int DW = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- single-lane DUT ----------------
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [1:0]    in_mode;
    logic [DW-1:0] in_data, out_data;

    pwl_act_pipe #(.DATA_W(DW), .FRAC_W(8), .LANES(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // ---------------- four-lane DUT ----------------
    logic          in_valid4, in_ready4, out_valid4, out_ready4;
    logic [1:0]    in_mode4;
    logic [63:0]   in_data4, out_data4;

    pwl_act_pipe #(.DATA_W(DW), .FRAC_W(8), .LANES(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_mode   (in_mode4),
        .in_data   (in_data4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_data  (out_data4)
    );

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    int            edge_q[$];
    logic [63:0]   exp4_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            n_out = 0;
    bit            chk_lat = 1'b1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 64'(exp_q.size()), 64'd1);
            end else begin
                check($sformatf("out_data#%0d", n_out), out_data, exp_q.pop_front());
                if (edge_q.size() != 0) begin
                    int ie;
                    ie = edge_q.pop_front();
                    if (chk_lat) check($sformatf("latency#%0d", n_out), 64'(cyc + 1 - ie), 64'd3);
                end
                n_out++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid4 && out_ready4) begin
            if (exp4_q.size() == 0) check("l4_unexpected", 64'(exp4_q.size()), 64'd1);
            else check("l4_out", out_data4, exp4_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    // Called and returning at posedge+1.
    task automatic send(input logic [1:0] m, input logic [DW-1:0] d);
        bit got;
        got = 1'b0;
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            got = in_ready;
            if (got) edge_q.push_back(cyc + 1);
            @(posedge clk);
            #1;
        end
        if (!got) check("send_timeout", 64'(got), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic xact(input logic [1:0] m, input logic [DW-1:0] d, input logic [DW-1:0] e);
        exp_q.push_back(e);
        send(m, d);
    endtask

    task automatic drain(input string tag);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 30) begin
            @(posedge clk);
            c++;
        end
        #1;
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    logic [DW-1:0] bp_in  [5] = '{16'h0010, 16'h0050, 16'h0090, 16'h0150, 16'h0280};
    logic [DW-1:0] bp_exp [5] = '{16'h0010, 16'h0050, 16'h0088, 16'h00D4, 16'h00F6};
    logic [DW-1:0] v_in   [4] = '{16'h0040, 16'h00C0, 16'hFF40, 16'h8000};
    logic [DW-1:0] v_out  [4] = '{16'h0040, 16'h00A0, 16'hFF60, 16'hFF01};
    logic [DW-1:0] held;
    logic [63:0]   d4, e4;
    bit            have, acc;
    int            idx;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_mode = MODE_TANH; in_data = '0; out_ready = 1'b1;
        in_valid4 = 1'b0; in_mode4 = MODE_TANH; in_data4 = '0; out_ready4 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid_rel", out_valid, 0);
        @(posedge clk); #1;

        // tanh, continuous valid
        xact(MODE_TANH, 16'h0040, 16'h0040);
        xact(MODE_TANH, 16'h00C0, 16'h00A0);
        xact(MODE_TANH, 16'hFF40, 16'hFF60);
        drain("drain_tanh");

        // tanh segment boundaries
        xact(MODE_TANH, 16'h007F, 16'h007F);
        xact(MODE_TANH, 16'h0080, 16'h0080);
        xact(MODE_TANH, 16'h0200, 16'h00F2);
        xact(MODE_TANH, 16'h0300, 16'h00FF);
        xact(MODE_TANH, 16'h8000, 16'hFF01);
        drain("drain_bound");

        // sigmoid
        xact(MODE_SIGMOID, 16'h0000, 16'h0080);
        xact(MODE_SIGMOID, 16'h0180, 16'h00D0);
        xact(MODE_SIGMOID, 16'hFE80, 16'h0030);
        xact(MODE_SIGMOID, 16'h7FFF, 16'h00FF);
        drain("drain_sigmoid");

        // mode changing every beat, same operand through several modes
        xact(MODE_RELU,    16'hFF00, 16'h0000);
        xact(MODE_TANH,    16'hFF00, 16'hFF40);
        xact(MODE_SIGMOID, 16'hFF00, 16'h0040);
        xact(MODE_IDENT,   16'hFF00, 16'hFF00);
        xact(MODE_RELU,    16'h0123, 16'h0123);
        xact(MODE_IDENT,   16'h8001, 16'h8001);
        drain("drain_mixed");

        // backpressure: out_ready low for 6 cycles while offering 5 beats
        chk_lat = 1'b0;
        for (int i = 0; i < 5; i++) exp_q.push_back(bp_exp[i]);
        out_ready = 1'b0;
        idx = 0; have = 1'b0;
        in_valid = 1'b1; in_mode = MODE_TANH; in_data = bp_in[0];
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            acc = in_ready && (idx < 5);
            if (acc) edge_q.push_back(cyc + 1);
            if (out_valid) begin
                if (have) check($sformatf("bp_hold#%0d", c), out_data, held);
                else begin held = out_data; have = 1'b1; end
            end
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 5) in_data = bp_in[idx];
                else in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("bp_accepted", 64'(idx), 64'd3);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_first", out_data, bp_exp[0]);
        @(posedge clk); #1;
        out_ready = 1'b1;
        while (idx < 5) begin
            send(MODE_TANH, bp_in[idx]);
            idx++;
        end
        drain("drain_bp");
        repeat (3) begin
            @(negedge clk);
            check("bp_no_dup", out_valid, 0);
        end
        @(posedge clk); #1;

        // reset with two beats in flight
        out_ready = 1'b0;
        send(MODE_TANH, 16'h00C0);
        send(MODE_TANH, 16'h0040);
        repeat (2) @(posedge clk);
        #1;
        check("mid_pre_valid", out_valid, 1);
        check("mid_pre_data", out_data, 16'h00A0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        exp_q.delete();
        edge_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("mid_no_stale#%0d", c), out_valid, 0);
        end
        check("mid_in_ready", in_ready, 1);
        @(posedge clk); #1;
        chk_lat = 1'b1;
        xact(MODE_TANH, 16'h0040, 16'h0040);
        drain("drain_post_rst");

        // four lanes, each lane fed a different operand on every beat
        in_valid4 = 1'b1;
        in_mode4  = MODE_TANH;
        for (int b = 0; b < 3; b++) begin
            for (int l = 0; l < 4; l++) begin
                d4[l*DW +: DW] = v_in[(l + b) % 4];
                e4[l*DW +: DW] = v_out[(l + b) % 4];
            end
            exp4_q.push_back(e4);
            in_data4 = d4;
            @(negedge clk);
            check($sformatf("l4_in_ready#%0d", b), in_ready4, 1);
            @(posedge clk); #1;
        end
        in_valid4 = 1'b0;
        begin
            int c;
            c = 0;
            while (exp4_q.size() != 0 && c < 20) begin
                @(posedge clk);
                c++;
            end
            #1;
            check("l4_drain", 64'(exp4_q.size()), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
